// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared encodings for the pushbutton conditioner.
//               - PRESSED / RELEASED : normalized button level encoding.
//               - chan_state_e       : per-channel conditioner state.
//               - cnt_width()        : counter width able to hold 0..max_count.
//               Optional feature macro: BUTTON_CONDITIONER_AUTOREPEAT_EN
//               (the REPEATING state is only reachable when it is defined).
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  localparam logic PRESSED  = 1'b1;
  localparam logic RELEASED = 1'b0;

  // IDLE_RELEASED : level 0, sample agrees with level
  // COUNTING      : level 0, sample disagrees, qualifying a press
  // IDLE_PRESSED  : level 1, waiting for the first auto-repeat
  // REPEATING     : level 1, first auto-repeat issued, running at the period
  typedef enum logic [1:0] {
    IDLE_RELEASED = 2'd0,
    COUNTING      = 2'd1,
    IDLE_PRESSED  = 2'd2,
    REPEATING     = 2'd3
  } chan_state_e;

  // Width of an unsigned counter that must hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One pushbutton channel: polarity normalization, SYNC_STAGES
//               flop synchronizer, stability-counter debounce, single-cycle
//               press/release pulses and (optionally) auto-repeat.
//               Optional feature macro: BUTTON_CONDITIONER_AUTOREPEAT_EN
// Ports       : Clk        - system clock
//               Reset      - synchronous active-high reset
//               raw        - raw asynchronous button input
//               level      - debounced pressed state (1 = pressed)
//               level_next - next-state level (lets the top register btn_any
//                            coincident with level)
//               press      - 1-cycle pulse on accepted press / repeat
//               rel        - 1-cycle pulse on accepted release
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 1000
  , parameter int REPEAT_PERIOD = 200
`endif
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic level_next,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  chan_state_e            state_q, state_d;

  logic pressed_in;
  logic s;

  assign pressed_in = (ACTIVE_LOW != 0) ? ~raw : raw;
  assign s          = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pressed_in};
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    state_d = state_q;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif

    unique case (state_q)
      IDLE_RELEASED, COUNTING: begin
        if (s != PRESSED) begin
          // Sample agrees with the released level: any partial count is a glitch.
          cnt_d   = '0;
          state_d = IDLE_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = PRESSED;
          press_d = 1'b1;
          state_d = IDLE_PRESSED;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = COUNTING;
        end
      end

      default: begin
        // Pressed states: the release is qualified in the background while the
        // repeat timer keeps running, so a bounce on release does not disturb
        // the repeat cadence.
        if (s == PRESSED) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = RELEASED;
          rel_d   = 1'b1;
          state_d = IDLE_RELEASED;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        // No repeat in the release cycle: only advance while still pressed.
        if (level_d == PRESSED) begin
          if (rpt_q == ((state_q == REPEATING) ? PER_LAST : DLY_LAST)) begin
            press_d = 1'b1;
            rpt_d   = '0;
            state_d = REPEATING;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
`endif
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q  <= {SYNC_STAGES{RELEASED}};
      cnt_q   <= '0;
      level_q <= RELEASED;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      state_q <= IDLE_RELEASED;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      state_q <= state_d;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign level      = level_q;
  assign level_next = level_d;
  assign press      = press_q;
  assign rel        = rel_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Pushbutton front end. N_CH independent button_channel
//               instances plus a registered OR of all debounced levels.
//               Optional feature macro: BUTTON_CONDITIONER_AUTOREPEAT_EN
//               (adds REPEAT_DELAY / REPEAT_PERIOD auto-repeat on btn_press).
// Ports       : Clk         - system clock
//               Reset       - synchronous active-high reset
//               btn_raw     - [N_CH] raw async buttons, polarity per ACTIVE_LOW
//               btn_level   - [N_CH] debounced pressed state, 1 = pressed
//               btn_press   - [N_CH] 1-cycle pulse on press (and repeats)
//               btn_release - [N_CH] 1-cycle pulse on release
//               btn_any     - OR of btn_level, coincident with it
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 1000
  , parameter int REPEAT_PERIOD = 200
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            btn_any
);

  logic [N_CH-1:0] level_next;
  logic            any_q, any_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      , .REPEAT_DELAY  (REPEAT_DELAY)
      , .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .Clk        (Clk),
      .Reset      (Reset),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .level_next (level_next[i]),
      .press      (btn_press[i]),
      .rel        (btn_release[i])
    );
  end

  // Registered from next-state levels so btn_any changes in the same cycle
  // as btn_level rather than one cycle later.
  always_comb begin
    any_d = |level_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      any_q <= RELEASED;
    end else begin
      any_q <= any_d;
    end
  end

  assign btn_any = any_q;

endmodule
`default_nettype wire
